// File: rtl/program_rom_loader_if.sv
// Fetch and nibble-load signals between the host/PC side (master) and the instruction ROM (slave).
interface program_rom_loader_if #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
);
    localparam int unsigned NW = DW / 2;

    logic [AW-1:0] addr;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          ld_start;
    logic          ld_valid;
    logic [NW-1:0] ld_nibble;
    logic          ld_ready;
    logic          ld_busy;
    logic          ld_done;

    modport master (
        output addr, ld_start, ld_valid, ld_nibble,
        input  instr, instr_valid, ld_ready, ld_busy, ld_done
    );

    modport slave (
        input  addr, ld_start, ld_valid, ld_nibble,
        output instr, instr_valid, ld_ready, ld_busy, ld_done
    );
endinterface

// File: rtl/program_rom_loader.sv
// Instruction memory with one-cycle registered fetch and a nibble-serial loader
// that rewrites every word from a 4-bit valid/ready host stream.
module program_rom_loader #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    program_rom_loader_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned NW    = DW / 2;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state;
    logic [AW-1:0] wptr;
    logic [NW-1:0] hold;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] instr_q;
    logic          instr_valid_q;
    logic          ld_ready_q;
    logic          ld_busy_q;
    logic          ld_done_q;
    logic          beat_c;
    logic          wr_en_c;

    // ld_ready_q is high exactly in LO/HI, so a beat needs no input-side decode of state.
    assign beat_c  = bus.ld_valid & ld_ready_q;
    assign wr_en_c = beat_c & (state == S_HI);

    // Loader FSM; status outputs are registered from the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            wptr       <= '0;
            hold       <= '0;
            ld_ready_q <= 1'b0;
            ld_busy_q  <= 1'b0;
            ld_done_q  <= 1'b0;
        end else begin
            ld_done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.ld_start) begin
                        wptr       <= '0;
                        state      <= S_LO;
                        ld_ready_q <= 1'b1;
                        ld_busy_q  <= 1'b1;
                    end
                end
                S_LO: begin
                    if (beat_c) begin
                        hold  <= bus.ld_nibble;
                        state <= S_HI;
                    end
                end
                S_HI: begin
                    if (beat_c) begin
                        if (wptr == LAST) begin
                            state      <= S_DONE;
                            ld_ready_q <= 1'b0;
                            ld_busy_q  <= 1'b0;
                            ld_done_q  <= 1'b1;
                        end else begin
                            wptr  <= wptr + AW'(1);
                            state <= S_LO;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state      <= S_IDLE;
                    ld_ready_q <= 1'b0;
                    ld_busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Storage array; reset clears it so an aborted load leaves no partial image.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en_c) begin
            mem[wptr] <= {bus.ld_nibble, hold};
        end
    end

    // Fetch port: frozen while loading, so the decoder never sees a half-written image.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
        end else if (!ld_busy_q) begin
            instr_q       <= mem[bus.addr];
            instr_valid_q <= 1'b1;
        end else begin
            instr_valid_q <= 1'b0;
        end
    end

    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.ld_ready    = ld_ready_q;
    assign bus.ld_busy     = ld_busy_q;
    assign bus.ld_done     = ld_done_q;

endmodule

// File: tb/tb_program_rom_loader.sv
// Bench for program_rom_loader: directed load/fetch scenarios, a wrap/latency
// vector table and a randomized run against a session-level reference model.
module tb_program_rom_loader;
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned NW    = DW / 2;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    program_rom_loader_if #(.AW(AW), .DW(DW)) bus ();

    program_rom_loader #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int done_pulses = 0;

    // Reference model: a load session is a count of accepted beats; word k is beats 2k, 2k+1.
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_instr;
    bit            m_valid;
    bit            m_active;
    bit            m_done;
    int            m_beats;
    logic [NW-1:0] m_lo;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] exp_instr;
        bit            exp_valid;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
        m_instr  = '0;
        m_valid  = 1'b0;
        m_active = 1'b0;
        m_done   = 1'b0;
        m_beats  = 0;
        m_lo     = '0;
    endtask

    task automatic model_edge(input logic [AW-1:0] a, input bit s, input bit v, input logic [NW-1:0] n);
        bit new_done;
        new_done = 1'b0;
        if (!m_active) begin
            m_instr = m_mem[a];
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (m_active) begin
            if (v) begin
                if (m_beats % 2 == 0) m_lo = n;
                else m_mem[m_beats / 2] = {n, m_lo};
                m_beats++;
                if (m_beats == 2 * int'(DEPTH)) begin
                    m_active = 1'b0;
                    new_done = 1'b1;
                end
            end
        end else if (!m_done && s) begin
            m_active = 1'b1;
            m_beats  = 0;
        end
        m_done = new_done;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".instr"},       32'(bus.instr),       32'(m_instr));
        check({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'(m_valid));
        check({tag, ".ld_ready"},    32'(bus.ld_ready),    32'(m_active));
        check({tag, ".ld_busy"},     32'(bus.ld_busy),     32'(m_active));
        check({tag, ".ld_done"},     32'(bus.ld_done),     32'(m_done));
    endtask

    // One clock: drive away from the edge, step the model on the edge, sample 1ns later.
    task automatic cycle(input logic [AW-1:0] a, input bit s, input bit v, input logic [NW-1:0] n,
                         input string tag);
        bus.addr      = a;
        bus.ld_start  = s;
        bus.ld_valid  = v;
        bus.ld_nibble = n;
        @(posedge clk);
        model_edge(a, s, v, n);
        #1;
        if (bus.ld_done) done_pulses++;
        compare_all(tag);
    endtask

    task automatic apply_reset(input string tag);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        compare_all(tag);
        check({tag, ".busy_const"},  32'(bus.ld_busy),  0);
        check({tag, ".ready_const"}, 32'(bus.ld_ready), 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    // Full session with word i = 0x11*i; optional gaps, stray start pulse and frozen-instr check.
    task automatic load_pattern(input int gap, input int start_after, input int hold_val, input string tag);
        done_pulses = 0;
        cycle(AW'(3), 1'b1, 1'b0, '0, {tag, ".start"});
        for (int b = 0; b < 2 * int'(DEPTH); b++) begin
            for (int g = 0; g < gap; g++)
                cycle(AW'($urandom), (b == start_after), 1'b0, NW'($urandom), {tag, ".gap"});
            cycle(AW'($urandom), (b == start_after + 1), 1'b1, NW'(b / 2), {tag, ".beat"});
            if (hold_val >= 0) begin
                check({tag, ".hold_instr"}, 32'(bus.instr), 32'(hold_val));
                if (b < 2 * int'(DEPTH) - 1) check({tag, ".hold_valid"}, 32'(bus.instr_valid), 0);
            end
        end
        check({tag, ".done_after_last"}, 32'(bus.ld_done), 1);
        cycle(AW'(0), 1'b0, 1'b0, '0, {tag, ".post0"});
        cycle(AW'(0), 1'b0, 1'b0, '0, {tag, ".post1"});
        check({tag, ".done_count"}, 32'(done_pulses), 1);
    endtask

    task automatic sweep(input bit pattern, input string tag);
        for (int a = 0; a < int'(DEPTH); a++) begin
            cycle(AW'(a), 1'b0, 1'b0, '0, tag);
            check({tag, ".const"}, 32'(bus.instr), pattern ? 32'(8'h11 * a) : 0);
            check({tag, ".valid_const"}, 32'(bus.instr_valid), 1);
        end
    endtask

    initial begin
        tbl[0] = '{addr: 4'd14, exp_instr: 8'hEE, exp_valid: 1'b1};
        tbl[1] = '{addr: 4'd15, exp_instr: 8'hFF, exp_valid: 1'b1};
        tbl[2] = '{addr: 4'd0,  exp_instr: 8'h00, exp_valid: 1'b1};
        tbl[3] = '{addr: 4'd1,  exp_instr: 8'h11, exp_valid: 1'b1};
        tbl[4] = '{addr: 4'd15, exp_instr: 8'hFF, exp_valid: 1'b1};
        tbl[5] = '{addr: 4'd7,  exp_instr: 8'h77, exp_valid: 1'b1};

        bus.addr      = '0;
        bus.ld_start  = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.ld_nibble = '0;
        model_reset();

        // Reset then fetch
        apply_reset("rst0");
        cycle(AW'(5), 1'b0, 1'b0, '0, "fetch_after_rst");
        check("fetch_after_rst.const", 32'(bus.instr), 0);
        check("fetch_after_rst.valid_const", 32'(bus.instr_valid), 1);

        // Back-to-back full load, then readback
        load_pattern(0, -10, -1, "full");
        sweep(1'b1, "sweep_full");

        // Clear, then gapped load must give the identical image
        apply_reset("rst1");
        load_pattern(2, -10, -1, "gapped");
        sweep(1'b1, "sweep_gapped");

        // Frozen fetch during load and an ignored start pulse after beat 7
        cycle(AW'(3), 1'b0, 1'b0, '0, "pre_busy");
        check("pre_busy.const", 32'(bus.instr), 32'h33);
        load_pattern(1, 7, 8'h33, "busy");
        sweep(1'b1, "sweep_busy");

        // Reset after 9 beats aborts and clears
        cycle(AW'(0), 1'b1, 1'b0, '0, "abort.start");
        for (int b = 0; b < 9; b++) cycle(AW'($urandom), 1'b0, 1'b1, NW'($urandom), "abort.beat");
        apply_reset("abort.rst");
        sweep(1'b0, "sweep_cleared");

        // Wrap and one-cycle latency table
        load_pattern(0, -10, -1, "reload");
        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].addr, 1'b0, 1'b0, '0, "wrap");
            check($sformatf("wrap[%0d].instr", i), 32'(bus.instr), 32'(tbl[i].exp_instr));
            check($sformatf("wrap[%0d].valid", i), 32'(bus.instr_valid), 32'(tbl[i].exp_valid));
        end

        // Randomized traffic with occasional async resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) apply_reset("rand.rst");
            cycle(AW'($urandom), ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
                  NW'($urandom), "rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Hard bound in case the clock loop never reaches the end
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/program_rom_loader.md
Name: program_rom_loader

Overview:
- Instruction memory that answers the program counter. Each cycle it takes the PC address and returns the stored instruction one clock later.
- Includes a nibble-serial loader FSM that fills the memory from a 4-bit host handshake interface before or between runs.
- Sits between program_counter (address source) and the instruction decoder (instruction sink).

Parameters:
AW, 4, address width; memory depth is 2**AW words
DW, 8, instruction width; must be even, load port carries DW/2 bits per beat

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  asynchronous active-low reset (rst=0 resets immediately)
addr  input  AW  fetch address from program counter
instr  output  DW  registered instruction for addr of previous cycle
instr_valid  output  1  instr holds a fresh fetch result
ld_start  input  1  request to begin a load session (sampled in IDLE only)
ld_valid  input  1  ld_nibble carries a data beat
ld_nibble  input  DW/2  load data beat, low half of a word first, then high half
ld_ready  output  1  loader accepts a beat this cycle
ld_busy  output  1  load session in progress
ld_done  output  1  one-cycle pulse after the last word is written

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: instr=0, instr_valid=0, ld_ready=0, ld_busy=0, ld_done=0.
  - Internal: FSM=IDLE, write pointer wptr=0, low-nibble holding register=0, all 2**AW memory words=0.
  - Reset asserted mid-load aborts the session; partial contents are discarded because they are cleared.
- Fetch path:
  - When ld_busy=0 at a rising edge: instr<=mem[addr], instr_valid<=1. Latency is exactly 1 cycle.
  - When ld_busy=1: instr holds its last value and instr_valid<=0.
  - Address wrap needs no special handling; any addr 0..2**AW-1 is legal. addr change from 15 to 0 returns mem[0] next cycle.
- Handshake: a beat transfers on a rising edge where ld_valid=1 and ld_ready=1.
  - ld_valid may be deasserted between beats for any number of cycles.
  - ld_nibble is ignored when no beat transfers.
- Loader FSM (states IDLE, LO, HI, DONE):
  - IDLE: ld_ready=0, ld_busy=0. If ld_start=1, set wptr<=0 and go to LO.
  - LO: ld_ready=1, ld_busy=1. On a beat, capture ld_nibble into the holding register and go to HI. Otherwise stay.
  - HI: ld_ready=1, ld_busy=1. On a beat, write mem[wptr]<={ld_nibble, holding}.
    - If wptr==2**AW-1, go to DONE.
    - Otherwise wptr<=wptr+1 and go to LO.
    - No beat: stay.
  - DONE: ld_ready=0, ld_busy=0, ld_done=1 for this single cycle. Go to IDLE unconditionally.
- ld_start is ignored in LO, HI and DONE. It does not restart or reset wptr.
- ld_ready, ld_busy and ld_done are decoded from the registered state only, never from inputs.
- Fetch resumes in DONE. The first fetch after a load sees the newly written contents; the write lands on the edge entering DONE, which precedes any DONE-cycle read.
- Memory contents persist across load sessions until overwritten or reset. A full session always rewrites every word.

Test Plan:
1. Reset then fetch: pulse rst=0 for 2 cycles, release, addr=5 -> instr=0x00, instr_valid=1 one edge after release; all ld_* = 0.
2. Full load: ld_start=1 for 1 cycle, then 32 back-to-back beats giving word i = 0x11*i (beats i, i) -> ld_busy=1 throughout, ld_done=1 for exactly one cycle after the 32nd beat. Then sweep addr 0..15 -> instr 0x00, 0x11, …, 0xFF, each one cycle after its addr.
3. Gapped handshake: same data as scenario 2 but ld_valid asserted only every third cycle -> identical memory image, no duplicated or skipped words, ld_done once.
4. Busy behaviour:
   - Before the load, addr=3 gives instr=0x33. During the load, instr stays 0x33 with instr_valid=0.
   - ld_start=1 pulsed after beat 7 -> ignored; load still completes at beat 32 with correct contents.
5. Reset mid-load: assert rst=0 after 9 beats -> ld_busy=0, ld_ready=0, FSM IDLE. Afterwards every address reads 0x00.
6. Wrap and latency: after load, addr sequence 14, 15, 0, 1 -> instr 0xEE, 0xFF, 0x00, 0x11, each lagging addr by exactly one cycle.
